// File: rtl/parity_frame_checker.sv
// Per-word parity checker that groups FRAME_LEN words into a frame, reports
// the per-word and per-frame pass/fail results and keeps a saturating count of failed words.
module parity_frame_checker #(
  parameter int unsigned W         = 3,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ECW       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           odd_mode,
  input  logic           i_valid,
  input  logic [W-1:0]   i,
  input  logic           p,
  output logic           pc_valid,
  output logic           pc,
  output logic           frame_done,
  output logic           frame_ok,
  output logic [ECW-1:0] err_count,
  output logic           busy
);

  localparam int unsigned IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           pass_q, pass_d;
  logic           odd_eff_q, odd_eff_d;
  logic           pc_valid_d, pc_d, frame_done_d, frame_ok_d, busy_d;
  logic [ECW-1:0] err_d;
  logic           mode_sel_c, ok_c, pass_all_c;

  // The first word of a frame uses the live odd_mode; later words use the value latched with it.
  assign mode_sel_c = (state_q == IDLE) ? odd_mode : odd_eff_q;
  assign ok_c       = ((^i ^ p) == mode_sel_c);
  assign pass_all_c = pass_q & ok_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pass_q     <= 1'b0;
      odd_eff_q  <= 1'b0;
      pc_valid   <= 1'b0;
      pc         <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      odd_eff_q  <= odd_eff_d;
      pc_valid   <= pc_valid_d;
      pc         <= pc_d;
      frame_done <= frame_done_d;
      frame_ok   <= frame_ok_d;
      err_count  <= err_d;
      busy       <= busy_d;
    end
  end

  // Next-state and registered-output logic; clr wins over a simultaneous word.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    odd_eff_d    = odd_eff_q;
    pc_valid_d   = 1'b0;
    pc_d         = pc;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok;
    err_d        = err_count;

    if (clr) begin
      state_d = IDLE;
      idx_d   = '0;
      pass_d  = 1'b0;
      err_d   = '0;
    end else if (i_valid) begin
      pc_valid_d = 1'b1;
      pc_d       = ok_c;
      if (!ok_c && !(&err_count)) begin
        err_d = err_count + ECW'(1);
      end
      unique case (state_q)
        IDLE: begin
          odd_eff_d = odd_mode;
          idx_d     = IW'(1);
          pass_d    = ok_c;
          state_d   = ACCUM;
        end
        ACCUM: begin
          pass_d = pass_all_c;
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
            frame_ok_d   = pass_all_c;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == ACCUM);
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized and directed bench for parity_frame_checker against a word-count/parity-count model.
module tb_parity_frame_checker;

  localparam int unsigned W  = 3;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst, clr, odd_mode, i_valid, p;
  logic [W-1:0] i;
  logic pc_valid, pc, frame_done, frame_ok, busy;
  logic [7:0] err_count;
  logic pc_valid2, pc2, frame_done2, frame_ok2, busy2;
  logic [1:0] err_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_count, m_err;
  bit m_pass, m_mode;
  bit e_pcv, e_pc, e_fd, e_fok;

  always #5 clk = ~clk;

  parity_frame_checker #(.W(W), .FRAME_LEN(FL), .ECW(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .odd_mode(odd_mode), .i_valid(i_valid),
    .i(i), .p(p), .pc_valid(pc_valid), .pc(pc), .frame_done(frame_done),
    .frame_ok(frame_ok), .err_count(err_count), .busy(busy));

  parity_frame_checker #(.W(W), .FRAME_LEN(FL), .ECW(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .odd_mode(odd_mode), .i_valid(i_valid),
    .i(i), .p(p), .pc_valid(pc_valid2), .pc(pc2), .frame_done(frame_done2),
    .frame_ok(frame_ok2), .err_count(err_count2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_err = 0; m_pass = 0; m_mode = 0;
    e_pcv = 0; e_pc = 0; e_fd = 0; e_fok = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_valid"},   32'(pc_valid),   32'(e_pcv));
    check({tag, ".pc"},         32'(pc),         32'(e_pc));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    check({tag, ".frame_ok"},   32'(frame_ok),   32'(e_fok));
    check({tag, ".busy"},       32'(busy),       32'(m_count != 0));
    check({tag, ".err_count"},  32'(err_count),  32'((m_err > 255) ? 255 : m_err));
    check({tag, ".err_count2"}, 32'(err_count2), 32'((m_err > 3) ? 3 : m_err));
    check({tag, ".pc_valid2"},  32'(pc_valid2),  32'(e_pcv));
    check({tag, ".frame_done2"},32'(frame_done2),32'(e_fd));
    check({tag, ".busy2"},      32'(busy2),      32'(m_count != 0));
  endtask

  // One clock: apply inputs, advance the model from the spec rules, compare after the edge.
  task automatic step(input string tag, input bit v, input int d, input bit par,
                      input bit om, input bit c);
    bit okw, pass;
    clr = c; i_valid = v; i = W'(d); p = par; odd_mode = om;
    @(posedge clk);
    #1;
    e_pcv = 0; e_fd = 0;
    if (c) begin
      m_count = 0; m_err = 0; m_pass = 0;
    end else if (v) begin
      if (m_count == 0) m_mode = om;
      okw = ((($countones(W'(d)) + int'(par)) % 2) == int'(m_mode));
      e_pcv = 1; e_pc = okw;
      if (!okw) m_err++;
      pass = (m_count == 0) ? okw : (m_pass && okw);
      m_pass = pass;
      m_count++;
      if (m_count == FL) begin
        e_fd = 1; e_fok = pass; m_count = 0;
      end
    end
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 0, $urandom_range(7), $urandom_range(1), $urandom_range(1), 0);
  endtask

  initial begin
    rst = 1; clr = 0; odd_mode = 0; i_valid = 0; i = '0; p = 0;
    model_reset();
    #1;
    check_all("reset");
    #12 rst = 0;
    idle(1);

    // even mode, all-pass frame
    step("f1w0", 1, 3'b000, 0, 0, 0);
    step("f1w1", 1, 3'b001, 1, 0, 0);
    step("f1w2", 1, 3'b101, 0, 0, 0);
    step("f1w3", 1, 3'b110, 0, 0, 0);
    idle(1);
    // even mode, two failing words
    step("f2w0", 1, 3'b000, 1, 0, 0);
    step("f2w1", 1, 3'b001, 1, 0, 0);
    step("f2w2", 1, 3'b111, 1, 0, 0);
    step("f2w3", 1, 3'b110, 1, 0, 0);
    check("f2.err_is_2", 32'(err_count), 32'd2);
    // odd mode latched at first word; toggle mid-frame ignored
    step("f3w0", 1, 3'b000, 1, 1, 0);
    step("f3w1", 1, 3'b001, 0, 1, 0);
    step("f3w2", 1, 3'b101, 1, 0, 0);
    step("f3w3", 1, 3'b111, 0, 0, 0);
    check("f3.frame_ok", 32'(frame_ok), 32'd1);
    // clr with simultaneous word discards it and the partial frame
    step("c0", 1, 3'b011, 0, 0, 0);
    step("c1", 1, 3'b010, 0, 0, 0);
    step("c2", 1, 3'b001, 0, 0, 1);
    check("clr.busy", 32'(busy), 32'd0);
    for (int k = 0; k < FL; k++) step("c_fresh", 1, k, 0, 0, 0);
    // saturation on the 2-bit counter
    step("sat_clr", 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step("sat", 1, 3'b001, 0, 0, 0);
    check("sat.err2", 32'(err_count2), 32'd3);
    check("sat.err8", 32'(err_count),  32'd5);
    // asynchronous reset between edges mid-frame
    step("r0", 1, 3'b001, 1, 0, 0);
    step("r1", 1, 3'b001, 1, 0, 0);
    i_valid = 0;
    #2 rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 0;
    idle(1);
    // spaced words still form a frame
    for (int k = 0; k < FL; k++) begin
      step("gap", 1, $urandom_range(7), $urandom_range(1), 1, 0);
      idle(3);
    end
    // random traffic
    for (int k = 0; k < 400; k++)
      step("rand", ($urandom_range(3) != 0), $urandom_range(7), $urandom_range(1),
           $urandom_range(1), ($urandom_range(24) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
